// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and defaults for the segment display share arbiter
// Contents: arbiter state enum, round-robin memory enum, owner codes,
//           default blank frame and default hold length, owner decode helper.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    // Which requester was granted most recently; used to break ties in IDLE.
    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_e;

    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_A    = 2'b01;
    localparam logic [1:0] OWNER_B    = 2'b10;

    localparam logic [63:0] BLANK_FRAME_DEFAULT = 64'h0;
    localparam int          HOLD_TICKS_DEFAULT  = 4;

    function automatic logic [1:0] owner_of(input state_e s);
        case (s)
            GNT_A:   owner_of = OWNER_A;
            GNT_B:   owner_of = OWNER_B;
            default: owner_of = OWNER_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/slice_timer.sv
// rtl/slice_timer.sv - saturating per-grant refresh tick counter
// Ports:
//   clk_fast  in   scan clock
//   rst       in   asynchronous active-high reset
//   clr       in   clear to zero (wins over tick_en)
//   tick_en   in   count one refresh tick
//   cnt       out  ticks seen in the current grant, saturates at HOLD_TICKS-1
//   expired   out  cnt has reached HOLD_TICKS-1
module slice_timer #(
    parameter  int HOLD_TICKS = 4,
    localparam int CW         = $clog2(HOLD_TICKS)
) (
    input  logic          clk_fast,
    input  logic          rst,
    input  logic          clr,
    input  logic          tick_en,
    output logic [CW-1:0] cnt,
    output logic          expired
);

    localparam logic [CW-1:0] LAST = CW'(HOLD_TICKS - 1);

    assign expired = (cnt == LAST);

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick_en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_share_arb.sv
// rtl/seg_share_arb.sv - two-requester time-sliced arbiter for a shared 8-digit display
// Ports:
//   clk_fast      in   scan clock shared with the display driver
//   rst           in   asynchronous active-high reset
//   tick          in   one pulse per full 8-digit scan
//   a_req/b_req   in   requester wants the display (level)
//   a_frame/b_frame in 64-bit frames, digit 0 in [7:0]
//   a_gnt/b_gnt   out  requester owns the display
//   seg_frame     out  registered frame for the display driver
//   owner         out  00 idle, 01 A, 10 B
//   switch_pulse  out  one-cycle pulse alongside each new owner
module seg_share_arb
    import seg_pkg::*;
#(
    parameter int          HOLD_TICKS  = HOLD_TICKS_DEFAULT,
    parameter logic [63:0] BLANK_FRAME = BLANK_FRAME_DEFAULT
) (
    input  logic        clk_fast,
    input  logic        rst,
    input  logic        tick,
    input  logic        a_req,
    input  logic [63:0] a_frame,
    input  logic        b_req,
    input  logic [63:0] b_frame,
    output logic        a_gnt,
    output logic        b_gnt,
    output logic [63:0] seg_frame,
    output logic [1:0]  owner,
    output logic        switch_pulse
);

    localparam int CW = $clog2(HOLD_TICKS);

    state_e        state;
    state_e        state_nxt;
    rr_e           rr_last;
    logic [CW-1:0] hold_cnt;
    logic          slice_expired;
    logic          state_change;

    assign state_change = (state_nxt != state);

    // The timer restarts on every owner change; ticks only count while someone owns the display.
    slice_timer #(
        .HOLD_TICKS(HOLD_TICKS)
    ) u_slice_timer (
        .clk_fast(clk_fast),
        .rst     (rst),
        .clr     (state_change),
        .tick_en (tick && (state != IDLE)),
        .cnt     (hold_cnt),
        .expired (slice_expired)
    );

    // Request drop is tested before slice expiry so a dropping competitor never wins a slice.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (a_req && b_req) begin
                    state_nxt = (rr_last == RR_B) ? GNT_A : GNT_B;
                end else if (a_req) begin
                    state_nxt = GNT_A;
                end else if (b_req) begin
                    state_nxt = GNT_B;
                end
            end
            GNT_A: begin
                if (!a_req) begin
                    state_nxt = b_req ? GNT_B : IDLE;
                end else if (b_req && tick && slice_expired) begin
                    state_nxt = GNT_B;
                end
            end
            GNT_B: begin
                if (!b_req) begin
                    state_nxt = a_req ? GNT_A : IDLE;
                end else if (a_req && tick && slice_expired) begin
                    state_nxt = GNT_A;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant outputs are registered from the next state so they track state exactly.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_last      <= RR_B;
            a_gnt        <= 1'b0;
            b_gnt        <= 1'b0;
            owner        <= OWNER_IDLE;
            switch_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            a_gnt        <= (state_nxt == GNT_A);
            b_gnt        <= (state_nxt == GNT_B);
            owner        <= owner_of(state_nxt);
            switch_pulse <= state_change;
            if (state_change && (state_nxt == GNT_A)) begin
                rr_last <= RR_A;
            end else if (state_change && (state_nxt == GNT_B)) begin
                rr_last <= RR_B;
            end
        end
    end

    // Frame follows the current owner one cycle behind the state.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            seg_frame <= BLANK_FRAME;
        end else begin
            case (state)
                GNT_A:   seg_frame <= a_frame;
                GNT_B:   seg_frame <= b_frame;
                default: seg_frame <= BLANK_FRAME;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_share_arb.sv
// tb/tb_seg_share_arb.sv - directed self-checking bench for seg_share_arb
module tb_seg_share_arb;

    logic        clk_fast = 1'b0;
    logic        rst;
    logic        tick;
    logic        a_req;
    logic [63:0] a_frame;
    logic        b_req;
    logic [63:0] b_frame;
    logic        a_gnt;
    logic        b_gnt;
    logic [63:0] seg_frame;
    logic [1:0]  owner;
    logic        switch_pulse;

    int tests = 0;
    int fails = 0;

    always #5 clk_fast = ~clk_fast;

    seg_share_arb #(
        .HOLD_TICKS (4),
        .BLANK_FRAME(64'h0)
    ) dut (
        .clk_fast    (clk_fast),
        .rst         (rst),
        .tick        (tick),
        .a_req       (a_req),
        .a_frame     (a_frame),
        .b_req       (b_req),
        .b_frame     (b_frame),
        .a_gnt       (a_gnt),
        .b_gnt       (b_gnt),
        .seg_frame   (seg_frame),
        .owner       (owner),
        .switch_pulse(switch_pulse)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_fast);
        #1;
        chk("mutex", {63'd0, a_gnt & b_gnt}, 64'd0);
    endtask

    task automatic tick_step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic ea, input logic eb,
                             input logic [1:0] eo, input logic esw);
        chk({tag, ".a_gnt"}, {63'd0, a_gnt}, {63'd0, ea});
        chk({tag, ".b_gnt"}, {63'd0, b_gnt}, {63'd0, eb});
        chk({tag, ".owner"}, {62'd0, owner}, {62'd0, eo});
        chk({tag, ".switch"}, {63'd0, switch_pulse}, {63'd0, esw});
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; a_req = 1'b0; b_req = 1'b0;
        a_frame = 64'h0; b_frame = 64'h0;
        step(); step();
        chk_state("reset", 1'b0, 1'b0, 2'b00, 1'b0);
        chk("reset.frame", seg_frame, 64'h0);
        chk("reset.hold", {62'd0, dut.hold_cnt}, 64'd0);
        rst = 1'b0;
        step();
        chk_state("idle", 1'b0, 1'b0, 2'b00, 1'b0);

        // A alone
        a_frame = 64'h0102030405060708;
        a_req = 1'b1;
        step();
        chk_state("a_only", 1'b1, 1'b0, 2'b01, 1'b1);
        chk("a_only.frame_lag", seg_frame, 64'h0);
        step();
        chk_state("a_only2", 1'b1, 1'b0, 2'b01, 1'b0);
        chk("a_only.frame", seg_frame, 64'h0102030405060708);
        a_frame = 64'h1122334455667788;
        step();
        chk("a_frame_update", seg_frame, 64'h1122334455667788);

        // Ticks without a competitor keep A and saturate the timer
        for (int i = 0; i < 10; i++) begin
            tick_step();
            step();
        end
        chk_state("a_kept", 1'b1, 1'b0, 2'b01, 1'b0);
        chk("hold_sat", {62'd0, dut.hold_cnt}, 64'd3);
        b_req = 1'b1;
        tick_step();
        chk_state("b_on_tick", 1'b0, 1'b1, 2'b10, 1'b1);
        chk("hold_clr", {62'd0, dut.hold_cnt}, 64'd0);

        // Reset mid GNT_B
        b_frame = 64'hA5A5A5A5_5A5A5A5A;
        step();
        chk("b_frame", seg_frame, 64'hA5A5A5A5_5A5A5A5A);
        a_req = 1'b0; b_req = 1'b0;
        rst = 1'b1;
        #1;
        chk_state("async_rst", 1'b0, 1'b0, 2'b00, 1'b0);
        chk("async_rst.frame", seg_frame, 64'h0);
        step();
        rst = 1'b0;
        step();
        chk_state("post_rst", 1'b0, 1'b0, 2'b00, 1'b0);

        // Simultaneous requests: A first, slices of 4 ticks
        a_req = 1'b1; b_req = 1'b1;
        step();
        chk_state("both_a_first", 1'b1, 1'b0, 2'b01, 1'b1);
        for (int i = 0; i < 3; i++) tick_step();
        chk_state("a_slice3", 1'b1, 1'b0, 2'b01, 1'b0);
        tick_step();
        chk_state("b_slice", 1'b0, 1'b1, 2'b10, 1'b1);
        for (int i = 0; i < 3; i++) tick_step();
        chk_state("b_slice3", 1'b0, 1'b1, 2'b10, 1'b0);
        tick_step();
        chk_state("a_again", 1'b1, 1'b0, 2'b01, 1'b1);

        // A drops while B waits -> B directly
        a_req = 1'b0;
        step();
        chk_state("drop_to_b", 1'b0, 1'b1, 2'b10, 1'b1);
        step();
        chk_state("drop_to_b2", 1'b0, 1'b1, 2'b10, 1'b0);

        // B drops while A waits -> A, then A drops alone -> IDLE
        a_req = 1'b1; b_req = 1'b0;
        step();
        chk_state("drop_to_a", 1'b1, 1'b0, 2'b01, 1'b1);
        a_req = 1'b0;
        step();
        chk_state("to_idle", 1'b0, 1'b0, 2'b00, 1'b1);
        step();
        chk_state("idle2", 1'b0, 1'b0, 2'b00, 1'b0);
        chk("idle.frame", seg_frame, 64'h0);

        // Last grant was A, so a tie now goes to B
        a_req = 1'b1; b_req = 1'b1;
        step();
        chk_state("tie_rr_b", 1'b0, 1'b1, 2'b10, 1'b1);
        for (int i = 0; i < 3; i++) tick_step();
        // Competitor drops on the expiring tick: B keeps the display
        a_req = 1'b0;
        tick_step();
        chk_state("drop_beats_expiry", 1'b0, 1'b1, 2'b10, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
